logic_161_timer_ctrl: RTL and testbench

//  Sequencer for a cascade of NSTAGE 74HC161-style 4-bit counter slices (CK/nCLR/nLOAD/ENP/INT/CO).

---
 rtl/logic_161_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_logic_161_timer_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_161_timer_ctrl.sv
// Interval-timer sequencer for a cascade of external 74HC161-style 4-bit counter slices.
// Optional IRQ latch with acknowledge when LOGIC_161_TIMER_IRQ_LATCH_EN is defined.
module logic_161_timer_ctrl #(
   parameter int NSTAGE   = 2,
   parameter int PRESCALE = 1,
   localparam int W       = 4 * NSTAGE
) (
   input  logic              CK,
   input  logic              CLR,
   input  logic              START,
   input  logic              STOP,
   input  logic              MODE,
   input  logic [W-1:0]      RELOAD,
   input  logic [NSTAGE-1:0] CO_IN,
   output logic              CNT_nCLR,
   output logic              CNT_nLOAD,
   output logic [W-1:0]      CNT_DATA,
   output logic [NSTAGE-1:0] CNT_ENP,
   output logic [NSTAGE-1:0] CNT_INT,
   output logic              BUSY,
   output logic              EXPIRE
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
   ,
   output logic              IRQ,
   input  logic              IRQ_ACK
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic        mode_q, mode_d;
   logic        expire_q, expire_d;

   logic tick;
   logic tc;
   logic tick_go;
   logic carry;

   assign tick    = (state_q == S_RUN) && (presc_q == PRESC_LAST);
   assign tc      = &CO_IN;
   // STOP or START abort the current tick so the slices freeze on the way out of RUN.
   assign tick_go = tick && !STOP && !START;

   always_ff @(posedge CK) begin
      if (CLR) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         mode_q   <= 1'b0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         mode_q   <= mode_d;
         expire_q <= expire_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (START && !STOP) state_d = S_LOAD;
         S_LOAD: begin
            if (STOP)       state_d = S_IDLE;
            else if (START) state_d = S_LOAD;
            else            state_d = S_RUN;
         end
         S_RUN: begin
            if (STOP)                     state_d = S_IDLE;
            else if (START)               state_d = S_LOAD;
            else if (tick && tc && !mode_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Mode is captured at LOAD and re-captured at each periodic reload.
   always_comb begin
      presc_d  = (state_q == S_RUN && !tick) ? presc_q + 16'd1 : 16'd0;
      mode_d   = mode_q;
      if (state_q == S_LOAD)
         mode_d = MODE;
      else if (tick_go && tc && mode_q)
         mode_d = MODE;
      expire_d = tick_go && tc;
   end

   always_comb begin
      CNT_nLOAD = 1'b1;
      CNT_ENP   = '0;
      case (state_q)
         S_LOAD: CNT_nLOAD = 1'b0;
         S_RUN: begin
            if (tick_go) begin
               if (!tc)
                  CNT_ENP = '1;
               else if (mode_q)
                  CNT_nLOAD = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // INT is the pure carry chain at all times so CO_IN always reflects the count.
   always_comb begin
      carry   = 1'b1;
      CNT_INT = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         CNT_INT[i] = carry;
         carry      = carry & CO_IN[i];
      end
   end

   assign CNT_nCLR = ~CLR;
   assign CNT_DATA = RELOAD;
   assign BUSY     = (state_q != S_IDLE);
   assign EXPIRE   = expire_q;

`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
   logic irq_q, irq_d;

   always_comb irq_d = expire_q | (irq_q & ~IRQ_ACK);

   always_ff @(posedge CK) begin
      if (CLR) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end

   assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_logic_161_timer_ctrl.sv
// Bench for logic_161_timer_ctrl: two DUTs (PRESCALE 1 and 3) each driving two modelled 161 slices,
// checked against a table, hand sequences and a cycle-level behavioural reference model.
module tb_logic_161_timer_ctrl;

   logic       CK = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] reload = 8'hFC;
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
   logic       irq_ack = 1'b0;
   logic       irq_a, irq_b;
`endif

   logic       nclr_a, nload_a, busy_a, exp_a;
   logic [7:0] data_a;
   logic [1:0] enp_a, int_a, co_a;
   logic       nclr_b, nload_b, busy_b, exp_b;
   logic [7:0] data_b;
   logic [1:0] enp_b, int_b, co_b;
   logic [3:0] qa [2];
   logic [3:0] qb [2];
   logic [7:0] cnt_a, cnt_b;

   int passCount = 0;
   int checkCount = 0;

   always #5 CK = ~CK;

   logic_161_timer_ctrl #(.NSTAGE(2), .PRESCALE(1)) dutA (
      .CK(CK), .CLR(clr), .START(start), .STOP(stop), .MODE(mode), .RELOAD(reload),
      .CO_IN(co_a), .CNT_nCLR(nclr_a), .CNT_nLOAD(nload_a), .CNT_DATA(data_a),
      .CNT_ENP(enp_a), .CNT_INT(int_a), .BUSY(busy_a), .EXPIRE(exp_a)
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
      , .IRQ(irq_a), .IRQ_ACK(irq_ack)
`endif
   );

   logic_161_timer_ctrl #(.NSTAGE(2), .PRESCALE(3)) dutB (
      .CK(CK), .CLR(clr), .START(start), .STOP(stop), .MODE(mode), .RELOAD(reload),
      .CO_IN(co_b), .CNT_nCLR(nclr_b), .CNT_nLOAD(nload_b), .CNT_DATA(data_b),
      .CNT_ENP(enp_b), .CNT_INT(int_b), .BUSY(busy_b), .EXPIRE(exp_b)
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
      , .IRQ(irq_b), .IRQ_ACK(irq_ack)
`endif
   );

   // Behavioural 74HC161 slices: async clear, sync load, count when ENP & ENT.
   for (genvar g = 0; g < 2; g++) begin : g_slice
      always @(posedge CK or negedge nclr_a) begin
         if (!nclr_a)                    qa[g] <= 4'h0;
         else if (!nload_a)              qa[g] <= data_a[4*g +: 4];
         else if (enp_a[g] && int_a[g])  qa[g] <= qa[g] + 4'h1;
      end
      always @(posedge CK or negedge nclr_b) begin
         if (!nclr_b)                    qb[g] <= 4'h0;
         else if (!nload_b)              qb[g] <= data_b[4*g +: 4];
         else if (enp_b[g] && int_b[g])  qb[g] <= qb[g] + 4'h1;
      end
      assign co_a[g] = (qa[g] == 4'hF) && int_a[g];
      assign co_b[g] = (qb[g] == 4'hF) && int_b[g];
   end

   assign cnt_a = {qa[1], qa[0]};
   assign cnt_b = {qb[1], qb[0]};

   // Reference model: phase 0 idle, 1 loading, 2 running; count kept as a plain integer.
   int mPhase [2];
   int mCount [2];
   int mPre   [2];
   bit mMode  [2];
   bit mExp   [2];
   bit mIrq   [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         mPhase[k] = 0; mCount[k] = 0; mPre[k] = 0; mMode[k] = 0; mExp[k] = 0; mIrq[k] = 0;
      end
   end

   task automatic modelStep(input int k, input int presc);
      bit tickNow;
      bit expPrev;
      expPrev = mExp[k];
      if (clr) begin
         mPhase[k] = 0; mPre[k] = 0; mExp[k] = 0; mCount[k] = 0; mMode[k] = 0; mIrq[k] = 0;
      end else begin
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
         mIrq[k] = expPrev || (mIrq[k] && !irq_ack);
`else
         mIrq[k] = expPrev;
`endif
         mExp[k] = 0;
         case (mPhase[k])
            0: if (start && !stop) mPhase[k] = 1;
            1: begin
               mCount[k] = int'(reload);
               mPre[k]   = 0;
               mMode[k]  = mode;
               mPhase[k] = stop ? 0 : (start ? 1 : 2);
            end
            default: begin
               tickNow = (mPre[k] == presc - 1);
               if (stop) mPhase[k] = 0;
               else if (start) mPhase[k] = 1;
               else if (tickNow) begin
                  if (mCount[k] == 255) begin
                     mExp[k] = 1;
                     if (mMode[k]) begin
                        mCount[k] = int'(reload);
                        mMode[k]  = mode;
                     end else begin
                        mPhase[k] = 0;
                     end
                  end else begin
                     mCount[k] = mCount[k] + 1;
                  end
               end
               mPre[k] = (mPhase[k] == 2 && !tickNow) ? mPre[k] + 1 : 0;
            end
         endcase
      end
   endtask

   always @(posedge CK) begin
      modelStep(0, 1);
      modelStep(1, 3);
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
      checkCount++;
      if (actual === required) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
   endtask

   task automatic applyStimulus(input bit c, input bit st, input bit sp, input bit md, input logic [7:0] rl);
      clr = c; start = st; stop = sp; mode = md; reload = rl;
   endtask

   // One clock edge, then compare both DUTs against the reference model.
   task automatic stepCycle();
      @(posedge CK);
      #1;
      checkOutput("modelA busy",   16'(busy_a), 16'(mPhase[0] != 0));
      checkOutput("modelA expire", 16'(exp_a),  16'(mExp[0]));
      checkOutput("modelA count",  16'(cnt_a),  16'(mCount[0]));
      checkOutput("modelB busy",   16'(busy_b), 16'(mPhase[1] != 0));
      checkOutput("modelB expire", 16'(exp_b),  16'(mExp[1]));
      checkOutput("modelB count",  16'(cnt_b),  16'(mCount[1]));
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
      checkOutput("modelA irq", 16'(irq_a), 16'(mIrq[0]));
      checkOutput("modelB irq", 16'(irq_b), 16'(mIrq[1]));
`endif
   endtask

   typedef struct {
      bit         clr, start, stop, mode;
      logic [7:0] reload;
      bit         busy, expire;
      logic [7:0] count;
   } vec_t;

   function automatic vec_t mkVec(bit c, bit st, bit sp, bit md, logic [7:0] rl,
                                  bit b, bit e, logic [7:0] cnt);
      vec_t v;
      v.clr = c; v.start = st; v.stop = sp; v.mode = md; v.reload = rl;
      v.busy = b; v.expire = e; v.count = cnt;
      return v;
   endfunction

   vec_t vecs [$];

   initial begin
      int cycles;
      int nibbleBad;
      logic [7:0] prevB;

      // One-shot, periodic, abort, restart and clear sequences for DUT A (PRESCALE=1).
      vecs.push_back(mkVec(1,0,0,0,8'hFC, 0,0,8'h00));
      vecs.push_back(mkVec(0,1,0,0,8'hFC, 1,0,8'h00));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFC));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFD));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFF));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 0,1,8'hFF));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 0,0,8'hFF));
      vecs.push_back(mkVec(0,1,0,1,8'hFC, 1,0,8'hFF));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFC));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFD));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFF));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,1,8'hFC));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFD));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFF));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,1,8'hFC));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFD));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 1,0,8'hFE));
      vecs.push_back(mkVec(0,0,1,1,8'hFC, 0,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,1,8'hFC, 0,0,8'hFE));
      vecs.push_back(mkVec(0,1,1,0,8'hFC, 0,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 0,0,8'hFE));
      vecs.push_back(mkVec(0,1,0,0,8'hFC, 1,0,8'hFE));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFC));
      vecs.push_back(mkVec(0,0,0,0,8'hFC, 1,0,8'hFD));
      vecs.push_back(mkVec(0,1,0,0,8'hF0, 1,0,8'hFD));
      vecs.push_back(mkVec(0,0,0,0,8'hF0, 1,0,8'hF0));
      vecs.push_back(mkVec(0,0,0,0,8'hF0, 1,0,8'hF1));
      vecs.push_back(mkVec(1,0,0,0,8'hF0, 0,0,8'h00));
      vecs.push_back(mkVec(0,0,0,0,8'hF0, 0,0,8'h00));

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].clr, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].reload);
         stepCycle();
         checkOutput($sformatf("vec%0d busy", i),   16'(busy_a), 16'(vecs[i].busy));
         checkOutput($sformatf("vec%0d expire", i), 16'(exp_a),  16'(vecs[i].expire));
         checkOutput($sformatf("vec%0d count", i),  16'(cnt_a),  16'(vecs[i].count));
      end

      // Cascade on DUT B (PRESCALE=3): 0E -> FF then terminal tick, 242 ticks of 3 cycles after the load edge.
      applyStimulus(0, 1, 0, 0, 8'h0E);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 8'h0E);
      cycles = 0;
      nibbleBad = 0;
      prevB = cnt_b;
      while (cycles < 1000 && exp_b !== 1'b1) begin
         stepCycle();
         cycles++;
         if (cnt_b[7:4] != prevB[7:4] && !(prevB[3:0] == 4'hF && cnt_b[3:0] == 4'h0))
            nibbleBad++;
         prevB = cnt_b;
      end
      checkOutput("cascade cycles to expire", 16'(cycles), 16'd727);
      checkOutput("cascade upper nibble steps", 16'(nibbleBad), 16'd0);
      checkOutput("cascade final count", 16'(cnt_b), 16'hFF);
      checkOutput("cascade busy after", 16'(busy_b), 16'd0);

      // Randomised traffic biased toward short intervals so expiries are frequent.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom % 97) == 0, ($urandom % 23) == 0, ($urandom % 41) == 0,
                       1'($urandom % 2),
                       (($urandom % 4) == 0) ? 8'($urandom) : {4'hF, 4'($urandom)});
`ifdef LOGIC_161_TIMER_IRQ_LATCH_EN
         irq_ack = ($urandom % 5) == 0;
`endif
         stepCycle();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
